rr_bus_arbiter: RTL and testbench

RR_BUS_ARBITER -- requirements
Module: rr_bus_arbiter

---
 rtl/rr_bus_arbiter_if.sv | 16 +
 rtl/rr_bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_rr_bus_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_bus_arbiter_if.sv
// Bus-request/grant bundle between the requesting masters and rr_bus_arbiter.
// master modport: requester side. slave modport: arbiter side.
interface rr_bus_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  localparam int SEL_W = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] breq;
  logic [NUM_MASTERS-1:0] bgrant;
  logic [SEL_W-1:0]       msel;
  logic                   bus_busy;
  logic                   preempt;

  modport master (output breq, input bgrant, msel, bus_busy, preempt);
  modport slave  (input breq, output bgrant, msel, bus_busy, preempt);
endinterface

// File: rtl/rr_bus_arbiter.sv
// Round-robin bus arbiter: IDLE -> GRANT -> TURN, one dead cycle between owners,
// registered one-hot grants, msel tracks the current/most recent owner.
// Optional tenure timeout is compiled in with macro ARB_TIMEOUT_EN; without it
// tenure is unbounded and preempt is tied low.
module rr_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int MAX_HOLD    = 64
) (
  input  logic             clk,
  input  logic             rst,
  rr_bus_arbiter_if.slave  bus
);
  localparam int SEL_W = $clog2(NUM_MASTERS);

  // Elaboration-time parameter range checks.
  if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_masters
    $error("rr_bus_arbiter: NUM_MASTERS out of range 2..8");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 1024) begin : g_bad_hold
    $error("rr_bus_arbiter: MAX_HOLD out of range 2..1024");
  end

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] bgrant_q, bgrant_d;
  logic [SEL_W-1:0]       msel_q, msel_d;
  logic [SEL_W-1:0]       last_q, last_d;

  logic                   win_found;
  logic [SEL_W-1:0]       win_idx;
  logic [SEL_W-1:0]       cand;
  logic                   owner_req;
  logic                   other_req;

`ifdef ARB_TIMEOUT_EN
  localparam int              HOLD_W   = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              preempt_q, preempt_d;
`endif

  // Round-robin pick: first requester scanning upward from last+1 with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = SEL_W'((int'(last_q) + k) % NUM_MASTERS);
      if (!win_found && bus.breq[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Owner still requesting / anyone else waiting (bgrant_q is one-hot in GRANT).
  assign owner_req = |(bus.breq & bgrant_q);
  assign other_req = |(bus.breq & ~bgrant_q);

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    bgrant_d = bgrant_q;
    msel_d   = msel_q;
    last_d   = last_q;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
    preempt_d = 1'b0;
`endif
    case (state_q)
      IDLE, TURN: begin
        bgrant_d = '0;
        if (win_found) begin
          state_d           = GRANT;
          bgrant_d[win_idx] = 1'b1;
          msel_d            = win_idx;
          last_d            = win_idx;
`ifdef ARB_TIMEOUT_EN
          hold_d            = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_d  = TURN;
          bgrant_d = '0;
        end
`ifdef ARB_TIMEOUT_EN
        // Forced end of tenure; owner is already "last", so lowest priority.
        else if (hold_q == HOLD_MAX && other_req) begin
          state_d   = TURN;
          bgrant_d  = '0;
          preempt_d = 1'b1;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d  = IDLE;
        bgrant_d = '0;
      end
    endcase
  end

  // Core state register; reset drops grants immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bgrant_q <= '0;
      msel_q   <= '0;
      last_q   <= SEL_W'(NUM_MASTERS - 1);
    end else begin
      state_q  <= state_d;
      bgrant_q <= bgrant_d;
      msel_q   <= msel_d;
      last_q   <= last_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter and one-cycle preempt pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end
  assign bus.preempt = preempt_q;
`else
  assign bus.preempt = 1'b0;
`endif

  assign bus.bgrant   = bgrant_q;
  assign bus.msel     = msel_q;
  assign bus.bus_busy = |bgrant_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench for rr_bus_arbiter (4 masters, MAX_HOLD=8).
module tb_rr_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;

  rr_bus_arbiter_if #(.NUM_MASTERS(4)) bus ();

  rr_bus_arbiter #(.NUM_MASTERS(4), .MAX_HOLD(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Every-cycle invariants: grant one-hot or zero, busy == |grant.
  always @(negedge clk) begin
    vecs++;
    if (!$onehot0(bus.bgrant) || (bus.bus_busy !== (|bus.bgrant))) begin
      errs++;
      $display("FAIL invariant: bgrant=%b bus_busy=%b", bus.bgrant, bus.bus_busy);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus.breq = '0;
    repeat (2) tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.breq = 4'b1111;
    repeat (2) tick;
    vecs++;
    if (bus.bgrant !== 4'b0000 || bus.msel !== 2'd0 || bus.bus_busy !== 1'b0 || bus.preempt !== 1'b0) begin
      errs++;
      $display("FAIL reset_state: bgrant=%b msel=%0d busy=%b preempt=%b want 0000/0/0/0",
               bus.bgrant, bus.msel, bus.bus_busy, bus.preempt);
    end
    bus.breq = '0;
    rst = 1'b0;
  endtask

  task automatic test_first_grant;
    do_reset;
    bus.breq = 4'b0001;
    tick;
    vecs++;
    if (bus.bgrant !== 4'b0001 || bus.msel !== 2'd0 || bus.bus_busy !== 1'b1) begin
      errs++;
      $display("FAIL first_grant: bgrant=%b msel=%0d busy=%b want 0001/0/1",
               bus.bgrant, bus.msel, bus.bus_busy);
    end
    // Others requesting must not disturb the owner.
    bus.breq = 4'b1111;
    repeat (3) begin
      tick;
      vecs++;
      if (bus.bgrant !== 4'b0001) begin
        errs++;
        $display("FAIL grant_hold: bgrant=%b want 0001", bus.bgrant);
      end
    end
  endtask

  task automatic test_rr_order;
    logic [3:0] exp_g [5];
    logic [1:0] exp_s [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset;
    bus.breq = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick;
      vecs++;
      if (bus.bgrant !== exp_g[k] || bus.msel !== exp_s[k]) begin
        errs++;
        $display("FAIL rr_order[%0d]: bgrant=%b msel=%0d want %b/%0d",
                 k, bus.bgrant, bus.msel, exp_g[k], exp_s[k]);
      end
      repeat (2) tick;
      vecs++;
      if (bus.bgrant !== exp_g[k]) begin
        errs++;
        $display("FAIL rr_tenure[%0d]: bgrant=%b want %b", k, bus.bgrant, exp_g[k]);
      end
      bus.breq = 4'b1111 & ~exp_g[k];
      tick;
      vecs++;
      if (bus.bgrant !== 4'b0000) begin
        errs++;
        $display("FAIL rr_turn[%0d]: bgrant=%b want 0000", k, bus.bgrant);
      end
      bus.breq = 4'b1111;
      if (k == 4) bus.breq = 4'b0000;
    end
    tick;
  endtask

  task automatic test_back_to_back;
    do_reset;
    bus.breq = 4'b0100;
    tick;
    vecs++;
    if (bus.bgrant !== 4'b0100 || bus.msel !== 2'd2) begin
      errs++;
      $display("FAIL b2b_grant2: bgrant=%b msel=%0d want 0100/2", bus.bgrant, bus.msel);
    end
    bus.breq = 4'b0010;
    tick;
    vecs++;
    if (bus.bgrant !== 4'b0000 || bus.msel !== 2'd2) begin
      errs++;
      $display("FAIL b2b_turn: bgrant=%b msel=%0d want 0000/2", bus.bgrant, bus.msel);
    end
    tick;
    vecs++;
    if (bus.bgrant !== 4'b0010 || bus.msel !== 2'd1) begin
      errs++;
      $display("FAIL b2b_grant1: bgrant=%b msel=%0d want 0010/1", bus.bgrant, bus.msel);
    end
    // Drop everything: TURN then IDLE, msel holds.
    bus.breq = 4'b0000;
    repeat (2) begin
      tick;
      vecs++;
      if (bus.bgrant !== 4'b0000 || bus.msel !== 2'd1) begin
        errs++;
        $display("FAIL turn_idle: bgrant=%b msel=%0d want 0000/1", bus.bgrant, bus.msel);
      end
    end
    // last=1: scan 2,3,0 -> master 0 beats master 1.
    bus.breq = 4'b0011;
    tick;
    vecs++;
    if (bus.bgrant !== 4'b0001 || bus.msel !== 2'd0) begin
      errs++;
      $display("FAIL rr_wrap: bgrant=%b msel=%0d want 0001/0", bus.bgrant, bus.msel);
    end
  endtask

  task automatic test_rst_mid;
    do_reset;
    bus.breq = 4'b0100;
    tick;
    vecs++;
    if (bus.bgrant !== 4'b0100) begin
      errs++;
      $display("FAIL rst_mid_pre: bgrant=%b want 0100", bus.bgrant);
    end
    rst = 1'b1;
    #1;
    vecs++;
    if (bus.bgrant !== 4'b0000 || bus.msel !== 2'd0 || bus.bus_busy !== 1'b0) begin
      errs++;
      $display("FAIL rst_async: bgrant=%b msel=%0d busy=%b want 0000/0/0",
               bus.bgrant, bus.msel, bus.bus_busy);
    end
    bus.breq = 4'b0110;
    tick;
    rst = 1'b0;
    tick;
    vecs++;
    if (bus.bgrant !== 4'b0010 || bus.msel !== 2'd1) begin
      errs++;
      $display("FAIL rst_first_arb: bgrant=%b msel=%0d want 0010/1", bus.bgrant, bus.msel);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout;
    do_reset;
    bus.breq = 4'b0001;
    tick;
    vecs++;
    if (bus.bgrant !== 4'b0001) begin
      errs++;
      $display("FAIL to_grant0: bgrant=%b want 0001", bus.bgrant);
    end
    for (int i = 1; i < 8; i++) begin
      tick;
      if (i == 2) bus.breq = 4'b1001;
      vecs++;
      if (bus.bgrant !== 4'b0001 || bus.preempt !== 1'b0) begin
        errs++;
        $display("FAIL to_hold[%0d]: bgrant=%b preempt=%b want 0001/0", i, bus.bgrant, bus.preempt);
      end
    end
    tick;
    vecs++;
    if (bus.bgrant !== 4'b0000 || bus.preempt !== 1'b1) begin
      errs++;
      $display("FAIL to_preempt: bgrant=%b preempt=%b want 0000/1", bus.bgrant, bus.preempt);
    end
    tick;
    vecs++;
    if (bus.bgrant !== 4'b1000 || bus.msel !== 2'd3 || bus.preempt !== 1'b0) begin
      errs++;
      $display("FAIL to_grant3: bgrant=%b msel=%0d preempt=%b want 1000/3/0",
               bus.bgrant, bus.msel, bus.preempt);
    end
    bus.breq = 4'b0001;
    repeat (2) tick;
    for (int i = 0; i < 110; i++) begin
      vecs++;
      if (bus.bgrant !== 4'b0001 || bus.preempt !== 1'b0) begin
        errs++;
        $display("FAIL to_saturate[%0d]: bgrant=%b preempt=%b want 0001/0", i, bus.bgrant, bus.preempt);
      end
      tick;
    end
    bus.breq = 4'b0101;
    tick;
    vecs++;
    if (bus.bgrant !== 4'b0000 || bus.preempt !== 1'b1) begin
      errs++;
      $display("FAIL to_late_preempt: bgrant=%b preempt=%b want 0000/1", bus.bgrant, bus.preempt);
    end
    tick;
    vecs++;
    if (bus.bgrant !== 4'b0100 || bus.preempt !== 1'b0) begin
      errs++;
      $display("FAIL to_grant2: bgrant=%b preempt=%b want 0100/0", bus.bgrant, bus.preempt);
    end
  endtask
`else
  task automatic test_timeout;
    do_reset;
    bus.breq = 4'b1001;
    tick;
    for (int i = 0; i < 100; i++) begin
      vecs++;
      if (bus.bgrant !== 4'b0001 || bus.preempt !== 1'b0) begin
        errs++;
        $display("FAIL unbounded[%0d]: bgrant=%b preempt=%b want 0001/0", i, bus.bgrant, bus.preempt);
      end
      tick;
    end
  endtask
`endif

  initial begin
    bus.breq = '0;
    test_reset;
    test_first_grant;
    test_rr_order;
    test_back_to_back;
    test_rst_mid;
    test_timeout;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
